// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: drains a registered-read FIFO into a packet-framed valid/ready stream
// Ports:
//   clk, rst             read-domain clock, async active-low reset shared with the FIFO read side
//   en                   1: fetch from FIFO, 0: stop reading and drain the prefetch buffer
//   Empty, DataOut       FIFO empty flag and read data (data valid the cycle after an accepted read)
//   RdEn                 FIFO read request
//   m_data/m_valid/m_ready/m_last  output stream, m_last closes each PKT_LEN-word packet
//   occupancy            words held in the prefetch buffer (not counting an in-flight read)
//   word_cnt             words handed off, wrapping
//   busy                 adapter not idle
module fifo_rd_stream_adapter #(
  parameter int DATA_W = 32,
  parameter int BUF_DEPTH = 4,
  parameter int PKT_LEN = 8,
  parameter int CNT_W = 16,
  localparam int OW = $clog2(BUF_DEPTH + 1),
  localparam int PW = $clog2(BUF_DEPTH),
  localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              Empty,
  input  logic [DATA_W-1:0] DataOut,
  output logic              RdEn,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [OW-1:0]     occupancy,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic pending;
  logic [PW-1:0] head, tail;
  logic [BW-1:0] beat;
  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [OW:0] fill;
  logic pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(BUF_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // The in-flight read reserves a slot, so a push can never hit a full buffer
  assign fill = {1'b0, occupancy} + (OW + 1)'(pending);
  assign RdEn = state == RUN && !Empty && fill < (OW + 1)'(BUF_DEPTH);
  assign m_valid = occupancy != '0;
  assign m_data = mem[head];
  assign m_last = m_valid && beat == BW'(PKT_LEN - 1);
  assign pop = m_valid && m_ready;
  always_ff @(posedge clk)
    if (pending) mem[tail] <= DataOut;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      busy <= 1'b0;
      pending <= 1'b0;
      occupancy <= '0;
      head <= '0;
      tail <= '0;
      beat <= '0;
      word_cnt <= '0;
    end else begin
      pending <= RdEn;
      occupancy <= occupancy + OW'(pending) - OW'(pop);
      if (pending) tail <= nxt(tail);
      if (pop) begin
        head <= nxt(head);
        beat <= beat == BW'(PKT_LEN - 1) ? '0 : beat + 1'b1;
        word_cnt <= word_cnt + 1'b1;
      end
      case (state)
        IDLE: if (en) begin
          state <= RUN;
          busy <= 1'b1;
        end
        RUN: if (!en) state <= DRAIN;
        DRAIN: if (en) state <= RUN;
          else if (occupancy == '0 && !pending) begin
            state <= IDLE;
            busy <= 1'b0;
          end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule
